// File: rtl/ctrl_word_sequencer.sv
// Control-word player: a small buffer of datapath control vectors replayed onto
// cw_out with per-word hold time, optional looping, single-step mode and abort.
module ctrl_word_sequencer #(
    parameter int CW_WIDTH = 21,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH),
    parameter int HOLD_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [CW_WIDTH-1:0] wr_data,
    input  logic                start,
    input  logic                stop,
    input  logic [AW-1:0]       last_idx,
    input  logic [HOLD_W-1:0]   hold_cycles,
    input  logic                loop_en,
    input  logic                step_mode,
    input  logic                step_req,
    output logic [CW_WIDTH-1:0] cw_out,
    output logic                cw_valid,
    output logic [AW-1:0]       idx,
    output logic                busy,
    output logic                done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_reg;
    logic [CW_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]       last_reg;
    logic [HOLD_W-1:0]   hold_len_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic                loop_reg;
    logic                step_reg;

    logic                advance;
    logic                at_last;
    logic [AW-1:0]       idx_next;

    // The buffer is frozen while a program plays so the replay is deterministic.
    always_ff @(posedge clk) begin
        if (wr_en && (state_reg == IDLE)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        advance  = step_reg ? step_req : (hold_cnt_reg == '0);
        at_last  = (idx == last_reg);
        idx_next = idx + AW'(1);
    end

    assign busy = (state_reg == RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cw_out       <= '0;
            cw_valid     <= 1'b0;
            idx          <= '0;
            done         <= 1'b0;
            hold_cnt_reg <= '0;
            hold_len_reg <= '0;
            last_reg     <= '0;
            loop_reg     <= 1'b0;
            step_reg     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cw_out   <= '0;
                    cw_valid <= 1'b0;
                    if (start && !stop) begin
                        state_reg    <= RUN;
                        last_reg     <= last_idx;
                        hold_len_reg <= hold_cycles;
                        loop_reg     <= loop_en;
                        step_reg     <= step_mode;
                        idx          <= '0;
                        cw_out       <= mem[0];
                        cw_valid     <= 1'b1;
                        hold_cnt_reg <= hold_cycles;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_reg <= IDLE;
                        cw_out    <= '0;
                        cw_valid  <= 1'b0;
                    end else if (advance) begin
                        hold_cnt_reg <= hold_len_reg;
                        if (!at_last) begin
                            idx    <= idx_next;
                            cw_out <= mem[idx_next];
                        end else if (loop_reg) begin
                            idx    <= '0;
                            cw_out <= mem[0];
                        end else begin
                            state_reg <= IDLE;
                            cw_out    <= '0;
                            cw_valid  <= 1'b0;
                            done      <= 1'b1;
                        end
                    end else if (!step_reg) begin
                        hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_word_sequencer.sv
// Bench for ctrl_word_sequencer: directed steps plus randomized programs checked
// against a cycle-count model of how long each word must stay on cw_out.
module tb_ctrl_word_sequencer;

    localparam int CW = 21;
    localparam int DP = 16;
    localparam int AW = 4;
    localparam int HW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [CW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] last_idx = '0;
    logic [HW-1:0] hold_cycles = '0;
    logic          loop_en = 1'b0;
    logic          step_mode = 1'b0;
    logic          step_req = 1'b0;
    logic [CW-1:0] cw_out;
    logic          cw_valid;
    logic [AW-1:0] idx;
    logic          busy;
    logic          done;

    logic [CW-1:0] mem_m [DP];
    int n_cmp = 0;
    int n_err = 0;

    ctrl_word_sequencer #(.CW_WIDTH(CW), .DEPTH(DP), .AW(AW), .HOLD_W(HW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .last_idx(last_idx), .hold_cycles(hold_cycles),
        .loop_en(loop_en), .step_mode(step_mode), .step_req(step_req),
        .cw_out(cw_out), .cw_valid(cw_valid), .idx(idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 32'(cw_valid), 32'd0);
        chk({tag, ".cw"}, 32'(cw_out), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    task automatic wr(input int a, input logic [CW-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        mem_m[a] = d;
    endtask

    // Non-looping run: word w must appear for hold+1 cycles (timed) or until a
    // step_req cycle (step), then done pulses with outputs cleared.
    task automatic run_prog(input int last, input int hold, input bit stepm, input bit poke);
        int held;
        bit adv;
        $display("run last=%0d hold=%0d step=%0d poke=%0d", last, hold, stepm, poke);
        start = 1'b1; last_idx = AW'(last); hold_cycles = HW'(hold);
        loop_en = 1'b0; step_mode = stepm;
        tick();
        start = 1'b0;
        for (int w = 0; w <= last; w++) begin
            held = 0;
            adv = 1'b0;
            while (!adv) begin
                chk("run.valid", 32'(cw_valid), 32'd1);
                chk("run.cw", 32'(cw_out), 32'(mem_m[w]));
                chk("run.idx", 32'(idx), 32'(w));
                chk("run.busy", 32'(busy), 32'd1);
                chk("run.done", 32'(done), 32'd0);
                if (stepm) begin
                    step_req = (held >= 6) || ($urandom_range(0, 2) == 0);
                    adv = step_req;
                end else begin
                    step_req = ($urandom_range(0, 1) == 1);
                    adv = (held == hold);
                end
                start = ($urandom_range(0, 3) == 0);
                if (poke && w == 0 && held == 0) begin
                    wr_en = 1'b1; wr_addr = AW'(1); wr_data = 21'h1FFFFF;
                end
                tick();
                held++;
                step_req = 1'b0; start = 1'b0; wr_en = 1'b0;
            end
        end
        chk("end.done", 32'(done), 32'd1);
        chk_idle("end");
    endtask

    initial begin
        logic [CW-1:0] old0;
        for (int i = 0; i < DP; i++) mem_m[i] = 'x;

        // Reset state
        tick(); tick();
        chk_idle("rst");
        chk("rst.idx", 32'(idx), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        reset = 1'b1;
        tick();

        wr(0, 21'h0C1A00);
        wr(1, 21'h0C1A80);
        wr(2, 21'h0C1000);

        run_prog(2, 0, 1'b0, 1'b0);
        tick();
        run_prog(2, 3, 1'b0, 1'b0);
        run_prog(2, 0, 1'b1, 1'b0);   // back-to-back start in the done cycle

        // Looping two-word program aborted with stop
        $display("loop last=1 hold=0 stop at cycle 7");
        start = 1'b1; last_idx = 4'd1; hold_cycles = 4'd0; loop_en = 1'b1; step_mode = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk("loop.cw", 32'(cw_out), 32'(mem_m[k % 2]));
            chk("loop.idx", 32'(idx), 32'(k % 2));
            chk("loop.valid", 32'(cw_valid), 32'd1);
            if (k == 6) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        chk_idle("stop");
        chk("stop.done", 32'(done), 32'd0);
        chk("stop.idx", 32'(idx), 32'd0);

        // Writes during RUN are dropped; replay shows original data
        run_prog(2, 1, 1'b0, 1'b1);
        run_prog(2, 0, 1'b0, 1'b0);

        // start+stop together in IDLE, and step_req in IDLE, do nothing
        $display("start+stop and step_req in idle");
        tick();
        start = 1'b1; stop = 1'b1; step_req = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0; step_req = 1'b0;
        chk_idle("ss");
        tick();
        chk_idle("ss2");

        // Single word looped indefinitely until stop
        $display("loop last=0 hold=2");
        start = 1'b1; last_idx = 4'd0; hold_cycles = 4'd2; loop_en = 1'b1; step_mode = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("l0.cw", 32'(cw_out), 32'(mem_m[0]));
            chk("l0.idx", 32'(idx), 32'd0);
            chk("l0.done", 32'(done), 32'd0);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_idle("l0stop");

        // Maximum hold value
        run_prog(1, 15, 1'b0, 1'b0);

        // Asynchronous reset mid-run at word 1
        $display("reset mid-run");
        start = 1'b1; last_idx = 4'd2; hold_cycles = 4'd0; loop_en = 1'b0; step_mode = 1'b0;
        tick();
        start = 1'b0;
        tick();
        chk("pre.idx", 32'(idx), 32'd1);
        reset = 1'b0;
        #1;
        chk_idle("arst");
        chk("arst.idx", 32'(idx), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        run_prog(2, 0, 1'b0, 1'b0);

        // Write to address 0 in the start cycle: old word plays, write commits
        $display("read-before-write at start");
        old0 = mem_m[0];
        tick();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 21'h0ABCDE;
        start = 1'b1; last_idx = 4'd0; hold_cycles = 4'd0; loop_en = 1'b0; step_mode = 1'b0;
        tick();
        wr_en = 1'b0; start = 1'b0;
        mem_m[0] = 21'h0ABCDE;
        chk("rbw.cw", 32'(cw_out), 32'(old0));
        tick();
        chk("rbw.done", 32'(done), 32'd1);
        run_prog(0, 0, 1'b0, 1'b0);

        // Randomized programs
        for (int r = 0; r < 8; r++) begin
            tick();
            for (int a = 0; a < DP; a++) wr(a, CW'($urandom));
            run_prog($urandom_range(0, DP - 1),
                     ($urandom_range(0, 4) == 0) ? 15 : $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ctrl_word_sequencer.md
Name: ctrl_word_sequencer

Overview:
- Synthesizable, parametrised control-word player for datapath bring-up.
- Replaces hand-sequenced stimulus with a loadable buffer of control vectors.
- Buffer holds up to DEPTH words. Each word is CW_WIDTH bits: the concatenated datapath control fields {Jump, RE_DMEM, WE_DMEM, Branch, WE_RF, Mode_DMEM, Select_WD_RF, Op_ALU, Select_PC_RS1, Select_SrcB_ALU, SignExt_Control}.
- Words replay onto the datapath control inputs with per-word hold time, looping, single-step mode and abort.

Parameters:
- CW_WIDTH, 21, control-word width in bits.
- DEPTH, 16, buffer entries; power of two, minimum 2.
- AW, log2(DEPTH) = 4, address/index width.
- HOLD_W, 4, width of the hold-cycle count.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  AW  buffer write address.
- wr_data  in  CW_WIDTH  buffer write data.
- start  in  1  begin playback at index 0.
- stop  in  1  abort playback.
- last_idx  in  AW  index of the final word to play; sampled at start.
- hold_cycles  in  HOLD_W  extra cycles each word is held; sampled at start.
- loop_en  in  1  wrap to index 0 after last_idx; sampled at start.
- step_mode  in  1  advance only on step_req; sampled at start.
- step_req  in  1  single-step advance pulse.
- cw_out  out  CW_WIDTH  registered control word driven to the datapath.
- cw_valid  out  1  cw_out holds a played word.
- idx  out  AW  index of the word currently on cw_out.
- busy  out  1  in RUN state.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE; cw_out=0, cw_valid=0, idx=0, busy=0, done=0; hold counter=0.
  - Buffer contents are not reset.
- States: IDLE, RUN. done is a registered pulse emitted on the RUN->IDLE transition.
- Writes:
  - Accepted only when busy=0; mem[wr_addr] <= wr_data on the edge.
  - wr_en while busy=1 is ignored, with no side effect.
- IDLE:
  - cw_out=0, cw_valid=0.
  - On start=1 and stop=0, on that edge:
    - latch last_idx, hold_cycles, loop_en, step_mode;
    - idx<=0, cw_out<=mem[0], cw_valid<=1, hold counter<=hold_cycles, busy<=1.
  - Latency: start sampled at edge N -> word 0 visible after edge N.
  - Same-cycle wr_en to address 0 with start: cw_out gets the pre-write mem[0] (read-before-write); the write still commits.
- RUN, timed mode (step_mode latched 0):
  - Each word stays on cw_out for exactly hold_cycles+1 cycles. The counter decrements each cycle and the word advances when it reaches 0.
  - Advance with idx<last: idx<=idx+1, cw_out<=mem[idx+1], counter reloaded.
  - Advance with idx==last and loop=1: idx<=0, cw_out<=mem[0], with no gap cycle.
  - Advance with idx==last and loop=0: go to IDLE; cw_out<=0, cw_valid<=0, busy<=0, done<=1 for one cycle.
- RUN, step mode:
  - hold counter is ignored; the word is held until a cycle with step_req=1, then advances per the same rules.
  - step_req while IDLE is ignored.
- stop=1 in RUN:
  - Go to IDLE next edge; cw_out<=0, cw_valid<=0, busy<=0.
  - No done pulse; idx keeps its last value.
- Simultaneous events:
  - stop and start in the same cycle: stop wins and state stays or returns to IDLE.
  - start while in RUN is ignored.
  - start in the cycle done is asserted is accepted (back-to-back runs allowed).
- last_idx=0: a single word is played; with loop_en=1 it is held indefinitely until stop.
- hold_cycles=all-ones: each word lasts 2^HOLD_W cycles.
- Reset asserted mid-run: immediate return to reset values; buffer preserved, so a new start replays the same program.

Test Plan:
- Load mem[0..2]=0x0C1A00, 0x0C1A80, 0x0C1000. Start with last_idx=2, hold=0, loop=0. Required: cw_out sequence 0x0C1A00, 0x0C1A80, 0x0C1000 on consecutive cycles; idx 0,1,2; cw_valid=1 for 3 cycles; done=1 on the 4th cycle with cw_out=0.
- Same program with hold=3. Required: each word held 4 cycles, done after 12 cycles of valid.
- Program with last_idx=1, loop=1, hold=0. Required: 0,1,0,1,... with no gap. Assert stop at cycle 7: cw_valid=0 next cycle, no done pulse, busy=0.
- step_mode=1, last_idx=2; step_req pulses at cycles 5, 9, 10. Required: word 0 held through cycle 5, word 1 through 9, word 2 at 10, done at 11.
- During RUN, wr_en to addr 1 with 0x1FFFFF. Required: mem unchanged, and the next run replays the original data. Also drive start+stop together in IDLE: busy stays 0.
- Pull reset low mid-run at word 1. Required: all outputs 0 immediately (asynchronous). After release, start: word 0 replays with its original contents.
